// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters plus a pending
// control-flow counter, producing the decode stall and issue-accept.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   q_rs/q_rt, q_*_en       decode source-register query
//   iss_valid/wr/rd/ctl     decode issue request
//   wb_valid/wb_rd          writeback release
//   kill_valid/kill_rd      squash release
//   ctl_done                control-flow resolve
//   stall, iss_accept       decode hold / allocation performed
//   busy_vec, ctl_busy      nonzero-counter views of registered state
//   err                     sticky underflow flag
module reg_scoreboard #(
   parameter int NREG = 8,
   parameter int AW   = 3,
   parameter int CW   = 2,
   parameter int CTLW = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   q_rs,
   input  logic [AW-1:0]   q_rt,
   input  logic            q_rs_en,
   input  logic            q_rt_en,
   input  logic            iss_valid,
   input  logic            iss_wr,
   input  logic [AW-1:0]   iss_rd,
   input  logic            iss_ctl,
   input  logic            wb_valid,
   input  logic [AW-1:0]   wb_rd,
   input  logic            kill_valid,
   input  logic [AW-1:0]   kill_rd,
   input  logic            ctl_done,
   output logic            stall,
   output logic            iss_accept,
   output logic [NREG-1:0] busy_vec,
   output logic            ctl_busy,
   output logic            err
);

   localparam logic [CW-1:0]   CMAX = '1;
   localparam logic [CTLW-1:0] KMAX = '1;

   logic [CW-1:0]   count    [NREG];
   logic [CW-1:0]   count_nx [NREG];
   logic [CTLW-1:0] ctl_cnt;
   logic [CTLW-1:0] ctl_nx;
   logic [NREG-1:0] uflow;
   logic            ctl_uflow;
   logic [CW:0]     up;
   logic [CW:0]     dn;
   logic [CTLW:0]   cup;
   logic [CTLW:0]   cdn;

   always_comb begin
      busy_vec = '0;
      for (int i = 0; i < NREG; i++)
         busy_vec[i] = (count[i] != '0);
   end

   assign ctl_busy = (ctl_cnt != '0);

   // Only registered state feeds the stall, so a release takes effect
   // one cycle after it happens.
   assign stall = ctl_busy
                | (q_rs_en & busy_vec[q_rs])
                | (q_rt_en & busy_vec[q_rt])
                | (iss_valid & iss_wr & (count[iss_rd] == CMAX))
                | (iss_valid & iss_ctl & (ctl_cnt == KMAX));

   assign iss_accept = iss_valid & ~stall;

   always_comb begin
      uflow = '0;
      up    = '0;
      dn    = '0;
      for (int i = 0; i < NREG; i++) begin
         up = {1'b0, count[i]}
            + {{CW{1'b0}}, (iss_accept & iss_wr & (iss_rd == AW'(i)))};
         dn = {{CW{1'b0}}, (wb_valid & (wb_rd == AW'(i)))}
            + {{CW{1'b0}}, (kill_valid & (kill_rd == AW'(i)))};
         // Increment is blocked at max, so up never exceeds CW bits.
         if (up < dn) begin
            uflow[i]    = 1'b1;
            count_nx[i] = '0;
         end else begin
            count_nx[i] = CW'(up - dn);
         end
      end
   end

   always_comb begin
      cup       = {1'b0, ctl_cnt} + {{CTLW{1'b0}}, (iss_accept & iss_ctl)};
      cdn       = {{CTLW{1'b0}}, ctl_done};
      ctl_uflow = (cup < cdn);
      ctl_nx    = ctl_uflow ? '0 : CTLW'(cup - cdn);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++)
            count[i] <= '0;
         ctl_cnt <= '0;
         err     <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++)
            count[i] <= count_nx[i];
         ctl_cnt <= ctl_nx;
         err     <= err | (|uflow) | ctl_uflow;
      end
   end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one task per scenario,
// inline checks, single summary line.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] q_rs, q_rt;
   logic       q_rs_en, q_rt_en;
   logic       iss_valid, iss_wr, iss_ctl;
   logic [2:0] iss_rd;
   logic       wb_valid;
   logic [2:0] wb_rd;
   logic       kill_valid;
   logic [2:0] kill_rd;
   logic       ctl_done;
   logic       stall, iss_accept, ctl_busy, err;
   logic [7:0] busy_vec;

   int total = 0;
   int bad   = 0;

   reg_scoreboard #(.NREG(8), .AW(3), .CW(2), .CTLW(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .q_rs(q_rs), .q_rt(q_rt), .q_rs_en(q_rs_en), .q_rt_en(q_rt_en),
      .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_rd(iss_rd),
      .iss_ctl(iss_ctl), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .kill_valid(kill_valid), .kill_rd(kill_rd), .ctl_done(ctl_done),
      .stall(stall), .iss_accept(iss_accept), .busy_vec(busy_vec),
      .ctl_busy(ctl_busy), .err(err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      q_rs = 3'd0; q_rt = 3'd0; q_rs_en = 1'b0; q_rt_en = 1'b0;
      iss_valid = 1'b0; iss_wr = 1'b0; iss_rd = 3'd0; iss_ctl = 1'b0;
      wb_valid = 1'b0; wb_rd = 3'd0;
      kill_valid = 1'b0; kill_rd = 3'd0; ctl_done = 1'b0;
   endtask

   // advance past the next rising edge; inputs are driven afterwards
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic issue(input logic [2:0] rd);
      idle();
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = rd;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      tick(); tick();
      #1;
      total++;
      if (busy_vec !== 8'h00 || ctl_busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL por_state got busy=%h ctl=%b err=%b exp 00/0/0",
                  busy_vec, ctl_busy, err);
      end
      rst_n = 1'b1;
      tick();
      issue(3'd3);
      issue(3'd3);
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h08) begin
         bad++;
         $display("FAIL pre_reset_busy got=%h exp=08", busy_vec);
      end
      q_rs = 3'd3; q_rs_en = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (busy_vec !== 8'h00 || ctl_busy !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got busy=%h ctl=%b err=%b exp 00/0/0",
                  busy_vec, ctl_busy, err);
      end
      total++;
      if (stall !== 1'b0) begin
         bad++;
         $display("FAIL reset_stall got=%b exp=0", stall);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_raw();
      idle();
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 3'd5;
      #1;
      total++;
      if (iss_accept !== 1'b1) begin
         bad++;
         $display("FAIL raw_accept got=%b exp=1", iss_accept);
      end
      tick();
      idle();
      q_rs = 3'd5; q_rs_en = 1'b1;
      #1;
      total++;
      if (stall !== 1'b1 || busy_vec !== 8'h20) begin
         bad++;
         $display("FAIL raw_stall got stall=%b busy=%h exp 1/20",
                  stall, busy_vec);
      end
      tick();
      tick();
      wb_valid = 1'b1; wb_rd = 3'd5;
      #1;
      total++;
      if (stall !== 1'b1) begin
         bad++;
         $display("FAIL raw_wb_cycle got=%b exp=1", stall);
      end
      tick();
      wb_valid = 1'b0;
      #1;
      total++;
      if (stall !== 1'b0 || busy_vec !== 8'h00) begin
         bad++;
         $display("FAIL raw_release got stall=%b busy=%h exp 0/00",
                  stall, busy_vec);
      end
      idle();
   endtask

   task automatic test_simul();
      issue(3'd2);
      idle();
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 3'd2;
      wb_valid = 1'b1; wb_rd = 3'd2;
      #1;
      total++;
      if (iss_accept !== 1'b1) begin
         bad++;
         $display("FAIL simul_accept got=%b exp=1", iss_accept);
      end
      tick();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h04) begin
         bad++;
         $display("FAIL simul_keep got=%h exp=04", busy_vec);
      end
      issue(3'd2);
      idle();
      wb_valid = 1'b1; wb_rd = 3'd2;
      kill_valid = 1'b1; kill_rd = 3'd2;
      tick();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h00 || err !== 1'b0) begin
         bad++;
         $display("FAIL simul_dec2 got busy=%h err=%b exp 00/0",
                  busy_vec, err);
      end
   endtask

   task automatic test_saturation();
      for (int k = 0; k < 3; k++) begin
         idle();
         iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 3'd7;
         #1;
         total++;
         if (iss_accept !== 1'b1) begin
            bad++;
            $display("FAIL sat_fill%0d got=%b exp=1", k, iss_accept);
         end
         tick();
      end
      #1;
      total++;
      if (stall !== 1'b1 || iss_accept !== 1'b0) begin
         bad++;
         $display("FAIL sat_block got stall=%b acc=%b exp 1/0",
                  stall, iss_accept);
      end
      tick();
      idle();
      // two releases must leave the register busy if count stayed at 3
      for (int k = 0; k < 2; k++) begin
         wb_valid = 1'b1; wb_rd = 3'd7;
         tick();
      end
      wb_valid = 1'b0;
      #1;
      total++;
      if (busy_vec !== 8'h80) begin
         bad++;
         $display("FAIL sat_hold got=%h exp=80", busy_vec);
      end
      wb_valid = 1'b1; wb_rd = 3'd7;
      tick();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h00 || err !== 1'b0) begin
         bad++;
         $display("FAIL sat_drain got busy=%h err=%b exp 00/0",
                  busy_vec, err);
      end
   endtask

   task automatic test_ctl();
      idle();
      iss_valid = 1'b1; iss_ctl = 1'b1;
      #1;
      total++;
      if (iss_accept !== 1'b1) begin
         bad++;
         $display("FAIL ctl_accept got=%b exp=1", iss_accept);
      end
      tick();
      idle();
      #1;
      total++;
      if (ctl_busy !== 1'b1 || stall !== 1'b1) begin
         bad++;
         $display("FAIL ctl_shadow got busy=%b stall=%b exp 1/1",
                  ctl_busy, stall);
      end
      iss_valid = 1'b1; iss_wr = 1'b1; iss_rd = 3'd1;
      #1;
      total++;
      if (iss_accept !== 1'b0) begin
         bad++;
         $display("FAIL ctl_block got=%b exp=0", iss_accept);
      end
      tick();
      idle();
      ctl_done = 1'b1;
      #1;
      total++;
      if (ctl_busy !== 1'b1) begin
         bad++;
         $display("FAIL ctl_done_cycle got=%b exp=1", ctl_busy);
      end
      tick();
      idle();
      #1;
      total++;
      if (ctl_busy !== 1'b0 || stall !== 1'b0 || busy_vec !== 8'h00) begin
         bad++;
         $display("FAIL ctl_clear got busy=%b stall=%b vec=%h exp 0/0/00",
                  ctl_busy, stall, busy_vec);
      end
   endtask

   task automatic test_underflow();
      idle();
      wb_valid = 1'b1; wb_rd = 3'd4;
      tick();
      idle();
      #1;
      total++;
      if (busy_vec !== 8'h00 || err !== 1'b1) begin
         bad++;
         $display("FAIL uflow_set got busy=%h err=%b exp 00/1",
                  busy_vec, err);
      end
      issue(3'd0);
      issue(3'd0);
      idle();
      tick();
      #1;
      total++;
      if (err !== 1'b1 || busy_vec !== 8'h01) begin
         bad++;
         $display("FAIL uflow_sticky got err=%b busy=%h exp 1/01",
                  err, busy_vec);
      end
      do_reset();
      #1;
      total++;
      if (err !== 1'b0) begin
         bad++;
         $display("FAIL uflow_reset got=%b exp=0", err);
      end
      idle();
      ctl_done = 1'b1;
      tick();
      idle();
      #1;
      total++;
      if (err !== 1'b1 || ctl_busy !== 1'b0) begin
         bad++;
         $display("FAIL ctl_uflow got err=%b busy=%b exp 1/0",
                  err, ctl_busy);
      end
      do_reset();
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_raw();
      test_simul();
      test_saturation();
      test_ctl();
      test_underflow();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Sequential write-tracking scoreboard for the 5-stage pipeline. It counts in-flight writes to each architectural register and in-flight control-flow instructions.
- Decode queries it with the incoming instruction's source registers. It returns a stall and an issue-accept.
- It is the producer side of read-after-write hazard detection: writes are allocated at issue and released at writeback or squash. Decode consumes the stall.

Parameters:
- NREG, 8, number of architectural registers.
- AW, 3, register address width (NREG = 2**AW).
- CW, 2, per-register pending-write counter width; saturation value 2**CW-1.
- CTLW, 2, pending control-flow counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- q_rs  in  AW  decode source register Rs (instr[10:8]).
- q_rt  in  AW  decode source register Rt (instr[7:5]).
- q_rs_en  in  1  instruction reads Rs.
- q_rt_en  in  1  instruction reads Rt (includes stores that read data register in [7:5]).
- iss_valid  in  1  decode presents an instruction this cycle.
- iss_wr  in  1  instruction writes a register.
- iss_rd  in  AW  destination register.
- iss_ctl  in  1  instruction is branch/jump.
- wb_valid  in  1  writeback retires a register write.
- wb_rd  in  AW  retired destination.
- kill_valid  in  1  squashed instruction releases its allocation.
- kill_rd  in  AW  squashed destination.
- ctl_done  in  1  one control-flow instruction resolved.
- stall  out  1  decode must hold (NOP injected downstream).
- iss_accept  out  1  allocation performed this cycle.
- busy_vec  out  NREG  registered: bit i = count[i]!=0.
- ctl_busy  out  1  registered: control counter != 0.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n=0, async): all count[i]=0, ctl_cnt=0, err=0. Resulting outputs: busy_vec=0, ctl_busy=0, stall=0, iss_accept=0. Reset mid-operation discards all pending state immediately.
- Combinational:
  - stall = ctl_busy | (q_rs_en & busy_vec[q_rs]) | (q_rt_en & busy_vec[q_rt]) | (iss_valid & iss_wr & count[iss_rd]==max) | (iss_valid & iss_ctl & ctl_cnt==max).
  - Stall uses registered state only. A release in cycle N clears the stall no earlier than cycle N+1; this is conservative by one cycle.
  - iss_accept = iss_valid & ~stall.
- Per-register update each clock: count[i] += inc_i - dec_i.
  - inc_i = iss_accept & iss_wr & iss_rd==i.
  - dec_i = (wb_valid & wb_rd==i) + (kill_valid & kill_rd==i), range 0..2.
  - Arithmetic is done at CW+1 bits.
  - Simultaneous issue and release of the same register: net change is the sum (+1-1 = unchanged).
  - wb and kill on the same register in one cycle: -2.
- Underflow: if the result is < 0, clamp to 0 and set err.
- Overflow cannot occur because issue is stalled at max.
- Control counter: ctl_cnt += (iss_accept & iss_ctl) - ctl_done. Same-cycle issue and done leaves it unchanged. ctl_done at 0 clamps to 0 and sets err.
- err is sticky until reset.
- All registers update only on posedge clk.
- No special-casing of r0; it is an ordinary register.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with count[3]=2 -> busy_vec=8'h00, ctl_busy=0, err=0 immediately; stall=0 with q_rs=3, q_rs_en=1.
- RAW stall: cycle0 issue iss_wr=1, iss_rd=5 -> iss_accept=1; cycle1 q_rs=5, q_rs_en=1 -> stall=1, busy_vec=8'h20. wb_valid with wb_rd=5 at cycle3 -> stall=0 at cycle4.
- Simultaneous events: count[2]=1; same cycle issue rd=2 and wb rd=2 -> count[2] stays 1 and busy_vec[2]=1. Next cycle wb rd=2 plus kill rd=2 with count=2 -> count 0, err=0.
- Saturation: issue rd=7 three times -> count[7]=3; fourth issue of rd=7 -> stall=1, iss_accept=0, count unchanged.
- Control shadow: issue iss_ctl=1 -> ctl_busy=1 and stall=1 for any query; ctl_done pulse -> ctl_busy=0 next cycle.
- Underflow: wb_valid with wb_rd=4 and count[4]=0 -> count stays 0, err=1 and remains 1 until rst_n=0.
